fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus between fetch and imem
interface fetch_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_data);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, imem request FSM and IF/ID register with stall/redirect
// Optional delivered-instruction counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          next_address_i,
  output logic [63:0]          cur_address_o,
  input  logic                 redirect_i,
  input  logic [63:0]          redirect_addr_i,
  input  logic                 stall_i,
  fetch_stage_if.master        imem,
  output logic                 ifid_valid_o,
  output logic [31:0]          ifid_instr_o,
  output logic [63:0]          ifid_pc_o,
  output logic [31:0]          fetch_count_o
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [63:0] hold_pc_q, hold_pc_d;
  logic        deliver;

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign cur_address_o  = pc_q;
  assign ifid_valid_o   = ifid_valid_q;
  assign ifid_instr_o   = ifid_instr_q;
  assign ifid_pc_o      = ifid_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    deliver      = 1'b0;
    // Redirect outranks stall and any same-cycle response.
    if (redirect_i) begin
      pc_d         = {redirect_addr_i[63:2], 2'b00};
      ifid_valid_d = 1'b0;
      hold_instr_d = 32'h0;
      hold_pc_d    = 64'h0;
      state_d      = REQ;
    end else begin
      case (state_q)
        BOOT: state_d = REQ;
        REQ: begin
          if (imem.imem_ready && !stall_i) begin
            ifid_instr_d = imem.imem_data;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
            pc_d         = {next_address_i[63:2], 2'b00};
            deliver      = 1'b1;
          end else if (imem.imem_ready) begin
            hold_instr_d = imem.imem_data;
            hold_pc_d    = pc_q;
            state_d      = HOLD;
          end else if (!stall_i) begin
            ifid_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ifid_instr_d = hold_instr_q;
            ifid_pc_d    = hold_pc_q;
            ifid_valid_d = 1'b1;
            pc_d         = {next_address_i[63:2], 2'b00};
            deliver      = 1'b1;
            state_d      = REQ;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= {RESET_PC[63:2], 2'b00};
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'h0;
      ifid_pc_q    <= 64'h0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 64'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 32'h0;
    end else if (deliver) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_count_o = cnt_q;
`else
  assign fetch_count_o = 32'h0;
`endif

  logic unused_bits;
  assign unused_bits = ^{next_address_i[1:0], redirect_addr_i[1:0], deliver};

endmodule
